// File: rtl/control_temporizador.sv
// Sequencing controller for contador_variable: runs a programmed number of counter periods,
// supports pause/cancel, and raises a latched alarm that software acknowledges.
module control_temporizador #(
  parameter int width_counter  = 4,
  parameter int width_periodos = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      iniciar,
  input  logic                      pausar,
  input  logic                      cancelar,
  input  logic                      reconocer,
  input  logic [width_counter-1:0]  periodo,
  input  logic [width_periodos-1:0] num_periodos,
  input  logic                      fin_cuenta,
  output logic                      en_contador,
  output logic                      modo_contador,
  output logic [width_counter-1:0]  entrada_contador,
  output logic [width_periodos-1:0] restantes,
  output logic [2:0]                estado,
  output logic                      alarma
);

  typedef enum logic [2:0] {
    REPOSO   = 3'd0,
    CONTANDO = 3'd1,
    PAUSA    = 3'd2,
    ALARMA   = 3'd3,
    VACIADO  = 3'd4
  } estado_t;

  localparam logic [width_periodos-1:0] uno_p  = width_periodos'(1);
  localparam logic [width_periodos-1:0] cero_p = '0;

  estado_t                   estado_q, estado_d;
  logic [width_counter-1:0]  periodo_q, periodo_d;
  logic [width_periodos-1:0] restantes_q, restantes_d;
  logic                      arranque_s;

  assign arranque_s = iniciar && (num_periodos != cero_p);

  // State and latched run parameters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q    <= REPOSO;
      periodo_q   <= '0;
      restantes_q <= '0;
    end else begin
      estado_q    <= estado_d;
      periodo_q   <= periodo_d;
      restantes_q <= restantes_d;
    end
  end

  // Next-state and period bookkeeping
  always_comb begin
    estado_d    = estado_q;
    periodo_d   = periodo_q;
    restantes_d = restantes_q;
    case (estado_q)
      REPOSO: begin
        if (arranque_s) begin
          periodo_d   = periodo;
          restantes_d = num_periodos;
          estado_d    = CONTANDO;
        end else begin
          estado_d = REPOSO;
        end
      end
      CONTANDO: begin
        // A tick on the final period ends the run even if a pause arrives with it
        if (cancelar) begin
          restantes_d = cero_p;
          estado_d    = VACIADO;
        end else if (fin_cuenta) begin
          restantes_d = restantes_q - uno_p;
          if (restantes_q == uno_p) begin
            estado_d = ALARMA;
          end else if (pausar) begin
            estado_d = PAUSA;
          end else begin
            estado_d = CONTANDO;
          end
        end else if (pausar) begin
          estado_d = PAUSA;
        end else begin
          estado_d = CONTANDO;
        end
      end
      PAUSA: begin
        if (cancelar) begin
          restantes_d = cero_p;
          estado_d    = VACIADO;
        end else if (pausar) begin
          estado_d = CONTANDO;
        end else begin
          estado_d = PAUSA;
        end
      end
      ALARMA: begin
        if (arranque_s) begin
          periodo_d   = periodo;
          restantes_d = num_periodos;
          estado_d    = CONTANDO;
        end else if (reconocer || cancelar) begin
          estado_d = REPOSO;
        end else begin
          estado_d = ALARMA;
        end
      end
      VACIADO: begin
        // With entrada forced to 0 the counter ticks exactly when it reaches cuenta=0
        if (fin_cuenta) begin
          estado_d = REPOSO;
        end else begin
          estado_d = VACIADO;
        end
      end
      default: begin
        estado_d    = REPOSO;
        restantes_d = cero_p;
      end
    endcase
  end

  // Moore output decode from the registered state
  always_comb begin
    en_contador      = 1'b0;
    modo_contador    = 1'b0;
    entrada_contador = periodo_q;
    alarma           = 1'b0;
    case (estado_q)
      REPOSO: begin
        en_contador   = 1'b0;
        modo_contador = 1'b0;
      end
      CONTANDO: begin
        en_contador   = 1'b1;
        modo_contador = 1'b1;
      end
      PAUSA: begin
        en_contador   = 1'b0;
        modo_contador = 1'b1;
      end
      ALARMA: begin
        alarma = 1'b1;
      end
      VACIADO: begin
        en_contador      = 1'b1;
        modo_contador    = 1'b1;
        entrada_contador = '0;
      end
      default: begin
        en_contador   = 1'b0;
        modo_contador = 1'b0;
      end
    endcase
  end

  assign restantes = restantes_q;
  assign estado    = estado_q;

endmodule
